// File: rtl/shift_seq_pkg.sv
// Shared types and shifter codes for the shift sequencer.
// Imported by shift_sequencer and shift_amt_counter.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

endpackage

// File: rtl/shift_amt_counter.sv
// Shift-amount down-counter with load, decrement and is-one flag.
// The flag lets the sequencer leave SHIFT without the count wrapping.
module shift_amt_counter
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             is_one_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i)
      cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller driving a 1-bit-per-cycle shifter.
// Optional abort input enabled by SHIFT_SEQ_ABORT_EN.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] operand,
  output logic [1:0]       shf_s,
  output logic [WIDTH-1:0] shf_in,
  input  logic [WIDTH-1:0] shf_out,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [CNT_W-1:0] amount_q, amount_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cnt_ld, cnt_dec, cnt_is_one;
  logic             abort_w;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  shift_amt_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cnt_ld),
    .dec_i    (cnt_dec),
    .val_i    (amount_q),
    .is_one_o (cnt_is_one)
  );

  // Next state, shifter codes and request capture.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    amount_d  = amount_q;
    dir_d     = dir_q;
    shf_s     = S_HOLD;
    shf_in    = shf_out;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort_w) begin
          operand_d = operand;
          amount_d  = amount;
          dir_d     = dir;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        shf_s   = S_LOAD;
        shf_in  = operand_q;
        cnt_ld  = 1'b1;
        state_d = (amount_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        shf_s   = dir_q ? S_LEFT : S_RIGHT;
        cnt_dec = 1'b1;
        if (cnt_is_one)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    if (abort_w && (state_q == LOAD || state_q == SHIFT))
      state_d = IDLE;
  end

  // Status and result next values.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == DONE);
    result_d = (state_q == DONE) ? shf_out : result_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      amount_q  <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      amount_q  <= amount_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural 16-bit shifter.
// Abort scenario built only with SHIFT_SEQ_ABORT_EN.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [3:0]  amount;
  logic [15:0] operand;
  logic [1:0]  shf_s;
  logic [15:0] shf_in;
  logic [15:0] shf_out;
  logic        busy;
  logic        done;
  logic [15:0] result;
`ifdef SHIFT_SEQ_ABORT_EN
  logic        abort;
`endif

  int total;
  int bad;
  int done_cnt;
  int done_at;
  logic [1:0] codes [0:31];

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dir     (dir),
    .amount  (amount),
    .operand (operand),
    .shf_s   (shf_s),
    .shf_in  (shf_in),
    .shf_out (shf_out),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      shf_out <= '0;
    else
      case (shf_s)
        2'b11: shf_out <= shf_in;
        2'b01: shf_out <= {shf_in[15], shf_in[15:1]};
        2'b10: shf_out <= {shf_in[14:0], shf_in[0]};
        default: ;
      endcase
  end

  task automatic issue(input logic [15:0] op, input logic d,
                       input logic [3:0] amt);
    @(negedge clk);
    operand = op;
    dir     = d;
    amount  = amt;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic watch(input int n);
    done_cnt = 0;
    done_at  = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      codes[k] = shf_s;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total += 5;
    if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++;
      $display("FAIL reset_done got=%b want=0", done); end
    if (result !== 16'h0) begin bad++;
      $display("FAIL reset_result got=%h want=0000", result); end
    if (shf_s !== 2'b00) begin bad++;
      $display("FAIL reset_shf_s got=%b want=00", shf_s); end
    if (shf_in !== 16'h0) begin bad++;
      $display("FAIL reset_shf_in got=%h want=0000", shf_in); end
    rst = 1'b1;
  endtask

  task automatic test_right();
    issue(16'h8004, 1'b0, 4'd2);
    watch(8);
    total += 6;
    if (result !== 16'hE001) begin bad++;
      $display("FAIL right_result got=%h want=e001", result); end
    if (done_cnt != 1) begin bad++;
      $display("FAIL right_done_cnt got=%0d want=1", done_cnt); end
    if (done_at != 4) begin bad++;
      $display("FAIL right_latency got=%0d want=4", done_at); end
    if (codes[0] !== 2'b11) begin bad++;
      $display("FAIL right_code0 got=%b want=11", codes[0]); end
    if (codes[1] !== 2'b01) begin bad++;
      $display("FAIL right_code1 got=%b want=01", codes[1]); end
    if (busy !== 1'b0) begin bad++;
      $display("FAIL right_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_left();
    logic [1:0] exp;
    issue(16'h0003, 1'b1, 4'd3);
    watch(8);
    total += 2;
    if (result !== 16'h001F) begin bad++;
      $display("FAIL left_result got=%h want=001f", result); end
    if (done_at != 5) begin bad++;
      $display("FAIL left_latency got=%0d want=5", done_at); end
    for (int k = 0; k < 5; k++) begin
      exp = (k == 0) ? 2'b11 : (k == 4) ? 2'b00 : 2'b10;
      total++;
      if (codes[k] !== exp) begin bad++;
        $display("FAIL left_code%0d got=%b want=%b", k, codes[k], exp); end
    end
  endtask

  task automatic test_zero();
    int shifts;
    issue(16'h1234, 1'b0, 4'd0);
    watch(6);
    shifts = 0;
    for (int k = 0; k < 6; k++)
      if (codes[k] == 2'b01 || codes[k] == 2'b10) shifts++;
    total += 4;
    if (result !== 16'h1234) begin bad++;
      $display("FAIL zero_result got=%h want=1234", result); end
    if (done_at != 2) begin bad++;
      $display("FAIL zero_latency got=%0d want=2", done_at); end
    if (done_cnt != 1) begin bad++;
      $display("FAIL zero_done_cnt got=%0d want=1", done_cnt); end
    if (shifts != 0) begin bad++;
      $display("FAIL zero_shift_codes got=%0d want=0", shifts); end
  endtask

  task automatic test_busy();
    logic busy_mid;
    busy_mid = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    issue(16'h8004, 1'b0, 4'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 1) begin
        busy_mid = busy;
        operand  = 16'h0001;
        dir      = 1'b1;
        amount   = 4'd1;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total += 4;
    if (busy_mid !== 1'b1) begin bad++;
      $display("FAIL busy_mid got=%b want=1", busy_mid); end
    if (done_cnt != 1) begin bad++;
      $display("FAIL busy_done_cnt got=%0d want=1", done_cnt); end
    if (done_at != 6) begin bad++;
      $display("FAIL busy_latency got=%0d want=6", done_at); end
    if (result !== 16'hF800) begin bad++;
      $display("FAIL busy_result got=%h want=f800", result); end
  endtask

  task automatic test_back_to_back();
    int a_at, b_at;
    logic [15:0] a_res, b_res;
    a_at = -1; b_at = -1;
    a_res = '0; b_res = '0;
    issue(16'h0010, 1'b0, 4'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done && a_at < 0) begin
        a_at    = k;
        a_res   = result;
        operand = 16'h0101;
        dir     = 1'b1;
        amount  = 4'd2;
        start   = 1'b1;
      end else begin
        start = 1'b0;
        if (done && b_at < 0) begin
          b_at  = k;
          b_res = result;
        end
      end
    end
    total += 4;
    if (a_at != 3) begin bad++;
      $display("FAIL b2b_first_at got=%0d want=3", a_at); end
    if (a_res !== 16'h0008) begin bad++;
      $display("FAIL b2b_first_res got=%h want=0008", a_res); end
    if (b_at != 8) begin bad++;
      $display("FAIL b2b_second_at got=%0d want=8", b_at); end
    if (b_res !== 16'h0407) begin bad++;
      $display("FAIL b2b_second_res got=%h want=0407", b_res); end
  endtask

  task automatic test_reset_mid();
    issue(16'h8004, 1'b0, 4'd5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total += 4;
    if (busy !== 1'b0) begin bad++;
      $display("FAIL rmid_busy got=%b want=0", busy); end
    if (result !== 16'h0) begin bad++;
      $display("FAIL rmid_result got=%h want=0000", result); end
    if (done !== 1'b0) begin bad++;
      $display("FAIL rmid_done got=%b want=0", done); end
    if (shf_s !== 2'b00) begin bad++;
      $display("FAIL rmid_shf_s got=%b want=00", shf_s); end
    @(negedge clk);
    rst = 1'b1;
    watch(10);
    total++;
    if (done_cnt != 0) begin bad++;
      $display("FAIL rmid_no_done got=%0d want=0", done_cnt); end
    issue(16'h0003, 1'b1, 4'd1);
    watch(6);
    total += 2;
    if (done_at != 3) begin bad++;
      $display("FAIL rmid_next_latency got=%0d want=3", done_at); end
    if (result !== 16'h0007) begin bad++;
      $display("FAIL rmid_next_result got=%h want=0007", result); end
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    issue(16'h8004, 1'b0, 4'd4);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++;
      $display("FAIL abort_busy got=%b want=0", busy); end
    if (shf_s !== 2'b00) begin bad++;
      $display("FAIL abort_shf_s got=%b want=00", shf_s); end
    watch(8);
    total += 2;
    if (done_cnt != 0) begin bad++;
      $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    if (result !== 16'h0007) begin bad++;
      $display("FAIL abort_result got=%h want=0007", result); end
    @(negedge clk);
    operand = 16'hAAAA;
    amount  = 4'd1;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++;
      $display("FAIL abort_blocks_start got=%b want=0", busy); end
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    start   = 1'b0;
    dir     = 1'b0;
    amount  = '0;
    operand = '0;
    rst     = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort   = 1'b0;
`endif
    test_reset();
    test_right();
    test_left();
    test_zero();
    test_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
